// File: rtl/led_pkg.sv
// Shared constants for the LED frame scheduler: geometry of one SRAM bank,
// the starvation threshold and the requester identifiers used to index the
// arbiter's request/grant vectors.
package led_pkg;

    localparam int LED_AW         = 8;
    localparam int LED_DW         = 16;
    localparam int LED_STARVE_MAX = 4;

    localparam int REQ_WR = 0;
    localparam int REQ_RD = 1;

endpackage

// File: rtl/led_port_arb.sv
// Two-way fixed-priority arbiter for the shared SRAM port. The default winner
// is chosen by i_rd_prio, but a requester that has been denied STARVE_MAX
// cycles in a row takes the port; if both are starved the reader wins.
module led_port_arb
    import led_pkg::*;
#(
    parameter int STARVE_MAX = LED_STARVE_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rd_prio,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    localparam int            CW  = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_MAX);

    logic [CW-1:0] r_wrWait;
    logic [CW-1:0] r_rdWait;
    logic          w_wrHungry;
    logic          w_rdHungry;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] c);
        return (c == LIM) ? c : c + CW'(1);
    endfunction

    // Pick the winner: starved reader, then starved writer, then default priority.
    always_comb begin
        w_wrHungry = (r_wrWait == LIM);
        w_rdHungry = (r_rdWait == LIM);
        o_gnt      = '0;
        if (!i_rst) begin
            if (i_req[REQ_WR] && i_req[REQ_RD]) begin
                if (w_rdHungry) begin
                    o_gnt[REQ_RD] = 1'b1;
                end else if (w_wrHungry) begin
                    o_gnt[REQ_WR] = 1'b1;
                end else if (i_rd_prio) begin
                    o_gnt[REQ_RD] = 1'b1;
                end else begin
                    o_gnt[REQ_WR] = 1'b1;
                end
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Count consecutive denied cycles per requester; clear on grant or when the request drops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrWait <= '0;
            r_rdWait <= '0;
        end else begin
            r_wrWait <= (i_req[REQ_WR] && !o_gnt[REQ_WR]) ? satInc(r_wrWait) : '0;
            r_rdWait <= (i_req[REQ_RD] && !o_gnt[REQ_RD]) ? satInc(r_rdWait) : '0;
        end
    end

endmodule

// File: rtl/led_frame_sched.sv
// Ping-pong frame scheduler for the LED driver. One single-port SRAM holds two
// banks: the reader always addresses the displayed bank, the writer the other.
// Banks swap on a Vsync falling edge once a full frame has been loaded.
module led_frame_sched
    import led_pkg::*;
#(
    parameter int AW         = LED_AW,
    parameter int DW         = LED_DW,
    parameter int STARVE_MAX = LED_STARVE_MAX
) (
    input  logic          i_gck,
    input  logic          i_rst,
    input  logic          i_vsync,
    input  logic          i_wr_req,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_wr_last,
    output logic          o_wr_gnt,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_gnt,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_vld,
    output logic          o_mem_cen,
    output logic          o_mem_wen,
    output logic [AW:0]   o_mem_addr,
    output logic [DW-1:0] o_mem_d,
    input  logic [DW-1:0] i_mem_q,
    output logic          o_disp_bank,
    output logic          o_frame_rdy,
    output logic          o_overrun
);

    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_memCen;
    logic          w_memWen;
    logic [AW:0]   w_memAddr;
    logic [DW-1:0] w_memD;
    logic          w_frameDone;
    logic          w_swap;

    logic          r_dispBank;
    logic          r_frameRdy;
    logic          r_vsQ;
    logic          r_overrun;
    logic          r_rdVld;
    logic [AW:0]   r_memAddr;
    logic [DW-1:0] r_memD;

    // Pack the two requests into the arbiter's ID-indexed vector.
    always_comb begin
        w_req         = '0;
        w_req[REQ_WR] = i_wr_req;
        w_req[REQ_RD] = i_rd_req;
    end

    led_port_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .i_clk     (i_gck),
        .i_rst     (i_rst),
        .i_rd_prio (i_vsync),
        .i_req     (w_req),
        .o_gnt     (w_gnt)
    );

    assign o_wr_gnt = w_gnt[REQ_WR];
    assign o_rd_gnt = w_gnt[REQ_RD];

    // Drive the SRAM in the grant cycle; when idle the address and data buses hold their last value.
    always_comb begin
        w_memCen  = 1'b1;
        w_memWen  = 1'b1;
        w_memAddr = r_memAddr;
        w_memD    = r_memD;
        if (i_rst) begin
            w_memAddr = '0;
            w_memD    = '0;
        end else if (o_wr_gnt) begin
            w_memCen  = 1'b0;
            w_memWen  = 1'b0;
            w_memAddr = {~r_dispBank, i_wr_addr};
            w_memD    = i_wr_data;
        end else if (o_rd_gnt) begin
            w_memCen  = 1'b0;
            w_memAddr = {r_dispBank, i_rd_addr};
        end
    end

    // A frame completes on a granted last word; a swap needs a Vsync falling edge plus a completed frame,
    // and a frame finishing on the edge cycle itself still qualifies.
    always_comb begin
        w_frameDone = o_wr_gnt & i_wr_last;
        w_swap      = r_vsQ & ~i_vsync & (r_frameRdy | w_frameDone);
    end

    // Bank ownership, frame-ready flag, overrun pulse, read-valid pipeline and held SRAM buses.
    always_ff @(posedge i_gck) begin
        if (i_rst) begin
            r_dispBank <= 1'b0;
            r_frameRdy <= 1'b0;
            r_vsQ      <= 1'b0;
            r_overrun  <= 1'b0;
            r_rdVld    <= 1'b0;
            r_memAddr  <= '0;
            r_memD     <= '0;
        end else begin
            r_vsQ     <= i_vsync;
            r_overrun <= w_frameDone & r_frameRdy;
            r_rdVld   <= o_rd_gnt;
            r_memAddr <= w_memAddr;
            r_memD    <= w_memD;
            if (w_swap) begin
                r_dispBank <= ~r_dispBank;
                r_frameRdy <= 1'b0;
            end else if (w_frameDone) begin
                r_frameRdy <= 1'b1;
            end
        end
    end

    assign o_mem_cen   = w_memCen;
    assign o_mem_wen   = w_memWen;
    assign o_mem_addr  = w_memAddr;
    assign o_mem_d     = w_memD;
    assign o_rd_vld    = r_rdVld & ~i_rst;
    assign o_rd_data   = i_mem_q;
    assign o_disp_bank = r_dispBank;
    assign o_frame_rdy = r_frameRdy;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_led_frame_sched.sv
// Testbench for led_frame_sched: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of banks, arbitration and
// frame handshake, with a simple SRAM model attached to the memory port.
module tb_led_frame_sched;
    import led_pkg::*;

    localparam int AW   = LED_AW;
    localparam int DW   = LED_DW;
    localparam int SMAX = LED_STARVE_MAX;

    logic          gck = 1'b0;
    logic          rst;
    logic          vsync;
    logic          wrReq;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          wrLast;
    logic          wrGnt;
    logic          rdReq;
    logic [AW-1:0] rdAddr;
    logic          rdGnt;
    logic [DW-1:0] rdData;
    logic          rdVld;
    logic          memCen;
    logic          memWen;
    logic [AW:0]   memAddr;
    logic [DW-1:0] memD;
    logic [DW-1:0] memQ;
    logic          dispBank;
    logic          frameRdy;
    logic          overrun;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state.
    int          mDisp, mFrame, mVsQ, mOverrun, mRdVld;
    int          mWrWait, mRdWait;
    int          mLastAddr, mLastD;
    int          mRdExp;
    bit          mRdExpVld;
    logic [DW-1:0] shadow [512];
    bit          shadowVld [512];

    always #5 gck = ~gck;

    led_frame_sched dut (
        .i_gck       (gck),
        .i_rst       (rst),
        .i_vsync     (vsync),
        .i_wr_req    (wrReq),
        .i_wr_addr   (wrAddr),
        .i_wr_data   (wrData),
        .i_wr_last   (wrLast),
        .o_wr_gnt    (wrGnt),
        .i_rd_req    (rdReq),
        .i_rd_addr   (rdAddr),
        .o_rd_gnt    (rdGnt),
        .o_rd_data   (rdData),
        .o_rd_vld    (rdVld),
        .o_mem_cen   (memCen),
        .o_mem_wen   (memWen),
        .o_mem_addr  (memAddr),
        .o_mem_d     (memD),
        .i_mem_q     (memQ),
        .o_disp_bank (dispBank),
        .o_frame_rdy (frameRdy),
        .o_overrun   (overrun)
    );

    // Single-port synchronous SRAM, 512x16, read data one cycle after access.
    logic [DW-1:0] sram [512];
    always @(posedge gck) begin
        if (!memCen) begin
            if (!memWen) sram[memAddr] <= memD;
            else         memQ <= sram[memAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs with the model mid-cycle, then advance the model.
    task automatic applyStimulus(input bit r, input bit vs, input bit wq, input int wa, input int wd,
                                 input bit wl, input bit rq, input int ra);
        int  expWg, expRg, expCen, expWen, expAddr, expD;
        bit  done, swap;
        rst    = r;
        vsync  = vs;
        wrReq  = wq;
        wrAddr = wa[AW-1:0];
        wrData = wd[DW-1:0];
        wrLast = wl;
        rdReq  = rq;
        rdAddr = ra[AW-1:0];
        @(negedge gck);

        expWg = 0;
        expRg = 0;
        if (!r) begin
            if (wq && rq) begin
                if (mRdWait >= SMAX)      expRg = 1;
                else if (mWrWait >= SMAX) expWg = 1;
                else if (vs)              expRg = 1;
                else                      expWg = 1;
            end else begin
                expWg = wq;
                expRg = rq;
            end
        end
        expCen = (expWg != 0 || expRg != 0) ? 0 : 1;
        expWen = (expWg != 0) ? 0 : 1;
        if (r) begin
            expAddr = 0;
            expD    = 0;
        end else if (expWg != 0) begin
            expAddr = ((1 - mDisp) * 256) + (wa % 256);
            expD    = wd % 65536;
        end else if (expRg != 0) begin
            expAddr = (mDisp * 256) + (ra % 256);
            expD    = mLastD;
        end else begin
            expAddr = mLastAddr;
            expD    = mLastD;
        end

        checkOutput("wrGnt",   32'(wrGnt),   32'(expWg));
        checkOutput("rdGnt",   32'(rdGnt),   32'(expRg));
        checkOutput("memCen",  32'(memCen),  32'(expCen));
        checkOutput("memWen",  32'(memWen),  32'(expWen));
        checkOutput("memAddr", 32'(memAddr), 32'(expAddr));
        checkOutput("memD",    32'(memD),    32'(expD));
        checkOutput("rdVld",   32'(rdVld),   r ? 32'd0 : 32'(mRdVld));
        if (!r && mRdVld != 0 && mRdExpVld)
            checkOutput("rdData", 32'(rdData), 32'(mRdExp));
        if (!r) begin
            checkOutput("dispBank", 32'(dispBank), 32'(mDisp));
            checkOutput("frameRdy", 32'(frameRdy), 32'(mFrame));
            checkOutput("overrun",  32'(overrun),  32'(mOverrun));
        end

        if (r) begin
            mDisp = 0; mFrame = 0; mVsQ = 0; mOverrun = 0; mRdVld = 0;
            mWrWait = 0; mRdWait = 0; mLastAddr = 0; mLastD = 0;
        end else begin
            mWrWait = (wq && expWg == 0) ? ((mWrWait + 1 > SMAX) ? SMAX : mWrWait + 1) : 0;
            mRdWait = (rq && expRg == 0) ? ((mRdWait + 1 > SMAX) ? SMAX : mRdWait + 1) : 0;
            if (expWg != 0) begin
                shadow[expAddr]    = wd[DW-1:0];
                shadowVld[expAddr] = 1'b1;
            end
            if (expRg != 0) begin
                mRdExp    = int'(shadow[expAddr]);
                mRdExpVld = shadowVld[expAddr];
            end
            mRdVld   = expRg;
            done     = (expWg != 0) && wl;
            mOverrun = (done && mFrame != 0) ? 1 : 0;
            swap     = (mVsQ != 0) && !vs && (mFrame != 0 || done);
            if (swap) begin
                mDisp  = 1 - mDisp;
                mFrame = 0;
            end else if (done) begin
                mFrame = 1;
            end
            mVsQ      = vs ? 1 : 0;
            mLastAddr = expAddr;
            mLastD    = expD;
        end
        @(posedge gck);
        #1;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535));
    endfunction

    initial begin
        mDisp = 0; mFrame = 0; mVsQ = 0; mOverrun = 0; mRdVld = 0;
        mWrWait = 0; mRdWait = 0; mLastAddr = 0; mLastD = 0;
        mRdExp = 0; mRdExpVld = 1'b0;
        for (int i = 0; i < 512; i++) begin
            shadow[i]    = '0;
            shadowVld[i] = 1'b0;
        end

        // Reset, then load a full frame into bank 1 with Vsync low.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++)
            applyStimulus(0, 0, 1, i, rnd16(), (i == 255), 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("loadFrameRdy", 32'(frameRdy), 32'd1);

        // Vsync falling edge swaps banks; then read word 5 of the new display bank.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("swapBank", 32'(dispBank), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Both requesters held high with Vsync high: starvation guard interleaves writes.
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 1, 1, i, rnd16(), 0, 1, i * 3);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        // Complete a frame, then complete another while still pending -> overrun.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 1, 10 + i, rnd16(), (i == 3), 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 1, 20 + i, rnd16(), (i == 2), 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Swap the pending frame, then finish a frame exactly on a falling edge,
        // then a falling edge with nothing loaded.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 7);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 30, rnd16(), 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 30);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset right after a read grant drops the in-flight read.
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 9);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("rstBank",  32'(dispBank), 32'd0);
        checkOutput("rstFrame", 32'(frameRdy), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with slowly toggling Vsync and rare resets.
        begin
            bit vs = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 19) == 0) vs = ~vs;
                applyStimulus($urandom_range(0, 399) == 0, vs,
                              $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)), rnd16(),
                              $urandom_range(0, 15) == 0,
                              $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
